sync_fifo_flags: RTL and testbench



---
 rtl/sync_fifo_pkg.sv | 32 +++
 rtl/sync_fifo_ram.sv | 63 ++++++
 rtl/sync_fifo_flags.sv | 119 +++++++++++
 tb/tb_sync_fifo_flags.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared definitions for the single-clock flagged FIFO:
//   - default data width / address width
//   - count type for the default geometry, plus a helper that gives the
//     count width for any address width (count must span 0..DEPTH inclusive)
//   - threshold compare functions used for almost_full / almost_empty
// No ports (package).
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  // Count needs one more bit than the address so that DEPTH itself fits.
  typedef logic [DEFAULT_ADDR_WIDTH:0] count_t;

  function automatic int unsigned count_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic thresh_ge(input int unsigned value,
                                     input int unsigned thresh);
    return value >= thresh;
  endfunction

  function automatic logic thresh_le(input int unsigned value,
                                     input int unsigned thresh);
    return value <= thresh;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// -----------------------------------------------------------------------------
// sync_fifo_ram
// Simple dual-port storage for sync_fifo_flags: one write port, one read port.
// REG_READ = 1 : read data is registered, updated only when rd_en is high,
//                and cleared by reset.
// REG_READ = 0 : read data is a combinational view of mem[rd_addr].
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high reset (read register only)
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe (registered mode only)
//   rd_addr  in   read address
//   rd_data  out  read data
// -----------------------------------------------------------------------------
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter bit REG_READ   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

  // NOTE: the storage array has no reset; occupancy is tracked by the
  // pointers, so stale contents are never observable and the array can map
  // onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  generate
    if (REG_READ) begin : g_reg_read
      // NOTE: state is updated with <= so every register samples values from
      // before the edge; a write and read of the same slot returns old data.
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_data <= '0;
        end else if (rd_en) begin
          rd_data <= mem[rd_addr];
        end
      end
    end else begin : g_comb_read
      logic unused_ctrl;
      assign unused_ctrl = reset ^ rd_en;
      assign rd_data     = mem[rd_addr];
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags
// Single-clock FIFO with exact occupancy count, programmable almost-full /
// almost-empty thresholds, write-while-full when a read frees a slot, and
// sticky overflow / underflow flags cleared by err_clr.
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through
// (data_out shows the head word combinationally); otherwise data_out is
// registered and valid the cycle after an accepted read.
// Ports:
//   clk           in   clock, all logic on posedge
//   reset         in   synchronous active-high reset
//   wr_en         in   write request
//   data_in       in   write data
//   rd_en         in   read request
//   data_out      out  read data
//   full          out  count == DEPTH
//   empty         out  count == 0
//   almost_full   out  count >= AFULL_THRESH
//   almost_empty  out  count <= AEMPTY_THRESH
//   count         out  occupancy 0..DEPTH
//   overflow      out  sticky: a write was rejected
//   underflow     out  sticky: a read was rejected
//   err_clr       in   clears overflow / underflow (a new event wins)
// -----------------------------------------------------------------------------
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = count_width(ADDR_WIDTH);

`ifdef SYNC_FIFO_FWFT_EN
  localparam bit REG_READ = 1'b0;
`else
  localparam bit REG_READ = 1'b1;
`endif

  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [CW-1:0]       count_next;
  logic                rd_acc;
  logic                wr_acc;

  // Acceptance is decided from registered state only; a read frees the slot
  // a simultaneous write into a full FIFO needs.
  always_comb begin
    rd_acc     = rd_en && !empty;
    wr_acc     = wr_en && (!full || rd_acc);
    count_next = count + {{ADDR_WIDTH{1'b0}}, wr_acc}
                       - {{ADDR_WIDTH{1'b0}}, rd_acc};
  end

  // Flags are registered from count_next so they always agree with count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      count        <= count_next;
      full         <= (count_next == CW'(DEPTH));
      empty        <= (count_next == '0);
      almost_full  <= thresh_ge(32'(count_next), AFULL_THRESH);
      almost_empty <= thresh_le(32'(count_next), AEMPTY_THRESH);

      if (wr_en && !wr_acc) overflow <= 1'b1;
      else if (err_clr)     overflow <= 1'b0;

      if (rd_en && !rd_acc) underflow <= 1'b1;
      else if (err_clr)     underflow <= 1'b0;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_READ   (REG_READ)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_flags
// Directed bench for sync_fifo_flags at DATA_WIDTH=8, ADDR_WIDTH=4 (DEPTH=16,
// almost_full at >=14, almost_empty at <=2). Inputs change 1 time unit after
// a rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_sync_fifo_flags;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sync_fifo_flags #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (4),
    .AFULL_THRESH  (14),
    .AEMPTY_THRESH (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
  endtask

  // Expected {full, almost_full, almost_empty, empty} for a given occupancy.
  function automatic logic [3:0] flags_for(input int n);
    return {n == DEPTH, n >= 14, n <= 2, n == 0};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    idle();
    total++;
    if (count !== 5'd0) begin
      bad++; $display("FAIL reset_count got=%0d want=0", count);
    end
    total++;
    if ({full, almost_full, almost_empty, empty, overflow, underflow} !== 6'b001100) begin
      bad++; $display("FAIL reset_flags got=%b want=001100",
                      {full, almost_full, almost_empty, empty, overflow, underflow});
    end
`ifndef SYNC_FIFO_FWFT_EN
    total++;
    if (data_out !== 8'h00) begin
      bad++; $display("FAIL reset_data got=%h want=00", data_out);
    end
`endif
  endtask

  // Writes 0x11..0x20; the 16th word fills the FIFO.
  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      wr_en   = 1'b1;
      data_in = 8'(8'h11 + i);
      tick();
      idle();
      total++;
      if (count !== 5'(i + 1)) begin
        bad++; $display("FAIL fill_count[%0d] got=%0d want=%0d", i, count, i + 1);
      end
      total++;
      if ({full, almost_full, almost_empty, empty} !== flags_for(i + 1)) begin
        bad++; $display("FAIL fill_flags[%0d] got=%b want=%b", i,
                        {full, almost_full, almost_empty, empty}, flags_for(i + 1));
      end
    end
  endtask

  task automatic test_overflow();
    wr_en   = 1'b1;
    data_in = 8'hAA;
    tick();
    idle();
    total++;
    if ({overflow, underflow, full, count} !== {3'b101, 5'd16}) begin
      bad++; $display("FAIL ovf_set got ovf=%b unf=%b full=%b cnt=%0d want 1 0 1 16",
                      overflow, underflow, full, count);
    end
    // A new rejected write in the same cycle as err_clr keeps the flag set.
    wr_en   = 1'b1;
    err_clr = 1'b1;
    tick();
    idle();
    total++;
    if (overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_set_wins got=%b want=1", overflow);
    end
    err_clr = 1'b1;
    tick();
    idle();
    total++;
    if (overflow !== 1'b0) begin
      bad++; $display("FAIL ovf_clear got=%b want=0", overflow);
    end
  endtask

  task automatic test_full_wr_rd();
    logic [7:0] exp;
`ifdef SYNC_FIFO_FWFT_EN
    total++;
    if (data_out !== 8'h11) begin
      bad++; $display("FAIL full_rw_data got=%h want=11", data_out);
    end
`endif
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    data_in = 8'h55;
    tick();
    idle();
`ifndef SYNC_FIFO_FWFT_EN
    total++;
    if (data_out !== 8'h11) begin
      bad++; $display("FAIL full_rw_data got=%h want=11", data_out);
    end
`endif
    total++;
    if ({full, overflow, count} !== {2'b10, 5'd16}) begin
      bad++; $display("FAIL full_rw_state got full=%b ovf=%b cnt=%0d want 1 0 16",
                      full, overflow, count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp = (i < 15) ? 8'(8'h12 + i) : 8'h55;
`ifdef SYNC_FIFO_FWFT_EN
      total++;
      if (data_out !== exp) begin
        bad++; $display("FAIL drain_data[%0d] got=%h want=%h", i, data_out, exp);
      end
`endif
      rd_en = 1'b1;
      tick();
      idle();
`ifndef SYNC_FIFO_FWFT_EN
      total++;
      if (data_out !== exp) begin
        bad++; $display("FAIL drain_data[%0d] got=%h want=%h", i, data_out, exp);
      end
`endif
      total++;
      if ({full, almost_full, almost_empty, empty, count} !==
          {flags_for(15 - i), 5'(15 - i)}) begin
        bad++; $display("FAIL drain_state[%0d] got=%b/%0d want=%b/%0d", i,
                        {full, almost_full, almost_empty, empty}, count,
                        flags_for(15 - i), 15 - i);
      end
    end
  endtask

  task automatic test_underflow();
    rd_en = 1'b1;
    tick();
    idle();
    total++;
    if ({underflow, empty, count} !== {2'b11, 5'd0}) begin
      bad++; $display("FAIL unf_set got unf=%b empty=%b cnt=%0d want 1 1 0",
                      underflow, empty, count);
    end
`ifndef SYNC_FIFO_FWFT_EN
    total++;
    if (data_out !== 8'h55) begin
      bad++; $display("FAIL unf_data_hold got=%h want=55", data_out);
    end
`endif
    err_clr = 1'b1;
    tick();
    idle();
    total++;
    if (underflow !== 1'b0) begin
      bad++; $display("FAIL unf_clear got=%b want=0", underflow);
    end
    // Empty with simultaneous write and read: write in, read rejected.
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    data_in = 8'h33;
    tick();
    idle();
    total++;
    if ({underflow, empty, count} !== {2'b10, 5'd1}) begin
      bad++; $display("FAIL empty_rw got unf=%b empty=%b cnt=%0d want 1 0 1",
                      underflow, empty, count);
    end
`ifdef SYNC_FIFO_FWFT_EN
    total++;
    if (data_out !== 8'h33) begin
      bad++; $display("FAIL empty_rw_data got=%h want=33", data_out);
    end
`endif
    rd_en = 1'b1;
    tick();
    idle();
`ifndef SYNC_FIFO_FWFT_EN
    total++;
    if (data_out !== 8'h33) begin
      bad++; $display("FAIL empty_rw_data got=%h want=33", data_out);
    end
`endif
    total++;
    if (count !== 5'd0) begin
      bad++; $display("FAIL empty_rw_count got=%0d want=0", count);
    end
    err_clr = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_stream();
    logic [7:0] q[$];
    logic [7:0] exp;
    int writes_left = 40;
    int reads_left  = 40;
    int cycles      = 0;
    logic we, re, ra, wa;
    while ((writes_left > 0 || reads_left > 0) && cycles < 2000) begin
      cycles++;
      we = (writes_left > 0) && ($urandom_range(0, 3) != 0);
      re = (reads_left > 0)  && ($urandom_range(0, 2) != 0);
      ra = re && (q.size() > 0);
      wa = we && ((q.size() < DEPTH) || ra);
      exp = (q.size() > 0) ? q[0] : 8'h00;
`ifdef SYNC_FIFO_FWFT_EN
      if (ra) begin
        total++;
        if (data_out !== exp) begin
          bad++; $display("FAIL stream_data cyc=%0d got=%h want=%h", cycles, data_out, exp);
        end
      end
`endif
      wr_en   = we;
      rd_en   = re;
      data_in = 8'($urandom);
      if (ra) begin
        void'(q.pop_front());
        reads_left--;
      end
      if (wa) begin
        q.push_back(data_in);
        writes_left--;
      end
      tick();
      idle();
`ifndef SYNC_FIFO_FWFT_EN
      if (ra) begin
        total++;
        if (data_out !== exp) begin
          bad++; $display("FAIL stream_data cyc=%0d got=%h want=%h", cycles, data_out, exp);
        end
      end
`endif
      total++;
      if ({full, almost_full, almost_empty, empty, count} !==
          {flags_for(q.size()), 5'(q.size())}) begin
        bad++; $display("FAIL stream_state cyc=%0d got=%b/%0d want=%b/%0d", cycles,
                        {full, almost_full, almost_empty, empty}, count,
                        flags_for(q.size()), q.size());
      end
    end
    total++;
    if (writes_left != 0 || reads_left != 0) begin
      bad++; $display("FAIL stream_timeout got w=%0d r=%0d left want 0 0",
                      writes_left, reads_left);
    end
    err_clr = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_mid_reset();
    rd_en = 1'b1;
    tick();
    idle();
    total++;
    if (underflow !== 1'b1) begin
      bad++; $display("FAIL mid_pre_unf got=%b want=1", underflow);
    end
    for (int i = 0; i < 9; i++) begin
      wr_en   = 1'b1;
      data_in = 8'(8'h40 + i);
      tick();
    end
    idle();
    total++;
    if (count !== 5'd9) begin
      bad++; $display("FAIL mid_pre_count got=%0d want=9", count);
    end
    reset = 1'b1;
    tick();
    idle();
    total++;
    if ({count, full, almost_full, almost_empty, empty, overflow, underflow} !==
        {5'd0, 6'b001100}) begin
      bad++; $display("FAIL mid_reset_state got cnt=%0d flags=%b want 0 001100", count,
                      {full, almost_full, almost_empty, empty, overflow, underflow});
    end
`ifndef SYNC_FIFO_FWFT_EN
    total++;
    if (data_out !== 8'h00) begin
      bad++; $display("FAIL mid_reset_data got=%h want=00", data_out);
    end
`endif
    wr_en   = 1'b1;
    data_in = 8'h77;
    tick();
    idle();
`ifdef SYNC_FIFO_FWFT_EN
    total++;
    if (data_out !== 8'h77) begin
      bad++; $display("FAIL mid_after_data got=%h want=77", data_out);
    end
`endif
    rd_en = 1'b1;
    tick();
    idle();
`ifndef SYNC_FIFO_FWFT_EN
    total++;
    if (data_out !== 8'h77) begin
      bad++; $display("FAIL mid_after_data got=%h want=77", data_out);
    end
`endif
    total++;
    if ({empty, count} !== {1'b1, 5'd0}) begin
      bad++; $display("FAIL mid_after_state got empty=%b cnt=%0d want 1 0", empty, count);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_full_wr_rd();
    test_underflow();
    test_stream();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
